// File: rtl/rep3_pkg.sv
// Shared definitions for the repetition-3 serial link.
// Holds the transmitter FSM state encoding, the number of identical chips
// sent per logical bit, and a helper giving the frame length in clk cycles.
// The majority-vote receiver on the other end of the link imports this too.
package rep3_pkg;

  localparam int CHIPS_PER_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Start bit + payload + stop bit, each repeated and each chip stretched.
  function automatic int frame_cycles(input int data_w, input int baud_div);
    return (data_w + 2) * CHIPS_PER_BIT * baud_div;
  endfunction

endpackage

// File: rtl/rep3_serial_tx_if.sv
// Handshake and serial-line bundle for rep3_serial_tx.
//   data_in / data_valid : payload offered by the producer
//   data_ready           : transmitter idle and able to take a word
//   tx_out               : serial line, idles high
//   tx_busy              : frame in progress
//   tx_done              : single-cycle pulse when a frame completes
// master = producer side, slave = transmitter side.
interface rep3_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, tx_out, tx_busy, tx_done
  );
endinterface

// File: rtl/chip_tick_gen.sv
// Chip timing divider.
// While en is high it counts clk cycles 0..BAUD_DIV-1 and raises tick for one
// cycle on the last cycle of every chip. Dropping en clears the count, so a
// fresh frame always starts its first chip from zero.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : count enable (high while a frame is on the line)
//   tick       : end-of-chip strobe
module chip_tick_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(BAUD_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  // Wrap to zero after the last cycle of a chip; hold at zero when disabled.
  // With BAUD_DIV=1 LAST is zero, so tick fires every enabled cycle.
  always_comb begin
    cnt_d = 8'd0;
    if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/rep3_serial_tx.sv
// Repetition-3 serial transmitter.
// A word accepted in IDLE is sent as start(0), payload LSB first, stop(1);
// every logical bit goes out as CHIPS_PER_BIT identical chips, each chip held
// for BAUD_DIV clk cycles. tx_out is registered, so the start bit appears on
// the cycle after the accepting edge.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of rep3_serial_tx_if (handshake + serial line)
module rep3_serial_tx
  import rep3_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rep3_serial_tx_if.slave       bus
);

  localparam logic [1:0] REP_LAST = 2'(CHIPS_PER_BIT - 1);
  localparam logic [4:0] BIT_LAST = 5'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        rep_q, rep_d;
  logic [4:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              chip_tick;
  logic              bit_end;

  chip_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != ST_IDLE),
    .tick  (chip_tick)
  );

  // A logical bit ends on the tick of its last repeated chip.
  assign bit_end = chip_tick && (rep_q == REP_LAST);

  // Next-state logic. The line value for the next bit is loaded at the same
  // edge the state/shift register move, which keeps tx_out registered without
  // an extra cycle of latency. The shift register moves once per logical bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != ST_IDLE && chip_tick) begin
      rep_d = bit_end ? 2'd0 : rep_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.data_valid) begin
          state_d = ST_START;
          shift_d = bus.data_in;
          rep_d   = 2'd0;
          bit_d   = 5'd0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            bit_d   = 5'd0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 5'd1;
            tx_d  = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Reset aborts any frame immediately: line high, no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      rep_q   <= 2'd0;
      bit_q   <= 5'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_ready = (state_q == ST_IDLE);
  assign bus.tx_busy    = (state_q != ST_IDLE);
  assign bus.tx_out     = tx_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Directed bench for rep3_serial_tx: a default instance (8 data bits, 4 clk
// per chip) and a narrow fast instance (4 data bits, 1 clk per chip).
// Inputs change and outputs are sampled on the falling edge.
module tb_rep3_serial_tx;
  import rep3_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rep3_serial_tx_if #(.DATA_W(8)) bus0 ();
  rep3_serial_tx_if #(.DATA_W(4)) bus1 ();

  rep3_serial_tx #(.DATA_W(8), .BAUD_DIV(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  rep3_serial_tx #(.DATA_W(4), .BAUD_DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkOutputWord(input string tag, input logic [31:0] observed,
                                 input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer a word on the default instance; returns right after the accepting edge.
  task automatic applyStimulus(input logic [7:0] word);
    @(negedge clk);
    bus0.data_valid = 1'b1;
    bus0.data_in    = word;
    @(posedge clk);
  endtask

  // Follow one default frame cycle by cycle. frame holds {stop, data, start},
  // bit 0 first on the line, 12 cycles per bit. With disturb set, a stray
  // valid pulse and data changes are applied in the middle of the frame.
  task automatic runFrame0(input string tag, input logic [9:0] frame, input bit disturb);
    logic [9:0] sh;
    for (int c = 1; c <= 122; c++) begin
      @(negedge clk);
      if (c == 1) bus0.data_valid = 1'b0;
      if (disturb && c == 30) begin
        bus0.data_valid = 1'b1;
        bus0.data_in    = 8'hFF;
      end
      if (disturb && c == 31) bus0.data_valid = 1'b0;
      if (disturb && c == 60) bus0.data_in = 8'h00;
      if (c <= 120) begin
        sh = frame >> ((c - 1) / 12);
        checkOutput({tag, "_tx"}, bus0.tx_out, sh[0]);
        checkOutput({tag, "_busy"}, bus0.tx_busy, 1'b1);
        checkOutput({tag, "_done_low"}, bus0.tx_done, 1'b0);
      end else if (c == 121) begin
        checkOutput({tag, "_done"}, bus0.tx_done, 1'b1);
        checkOutput({tag, "_ready"}, bus0.data_ready, 1'b1);
        checkOutput({tag, "_idle_tx"}, bus0.tx_out, 1'b1);
      end else begin
        checkOutput({tag, "_done_once"}, bus0.tx_done, 1'b0);
        checkOutput({tag, "_ready_after"}, bus0.data_ready, 1'b1);
      end
    end
  endtask

  initial begin
    int         done_cnt;
    int         first_done;
    int         second_done;
    logic [17:0] pat;
    logic [29:0] chips;
    logic [29:0] t;
    logic [2:0]  v;
    logic [9:0]  decoded;
    logic [7:0]  word;
    int          flip;

    rst_n           = 1'b0;
    bus0.data_valid = 1'b0;
    bus0.data_in    = 8'h00;
    bus1.data_valid = 1'b0;
    bus1.data_in    = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", bus0.tx_out, 1'b1);
    checkOutput("rst_ready", bus0.data_ready, 1'b1);
    checkOutput("rst_busy", bus0.tx_busy, 1'b0);
    checkOutput("rst_done", bus0.tx_done, 1'b0);
    checkOutput("rst_tx1", bus1.tx_out, 1'b1);

    // 0xA5 accepted on the first edge after reset release
    rst_n           = 1'b1;
    bus0.data_valid = 1'b1;
    bus0.data_in    = 8'hA5;
    @(posedge clk);
    runFrame0("a5", 10'b1_10100101_0, 1'b0);

    // Back-to-back 0x00 then 0xFF, valid held high
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    applyStimulus(8'h00);
    for (int c = 1; c <= 250; c++) begin
      @(negedge clk);
      if (c == 1) bus0.data_in = 8'hFF;
      if (c == 122) bus0.data_valid = 1'b0;
      if (bus0.tx_done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
      end
      if (c == 13) checkOutput("b2b_first_data", bus0.tx_out, 1'b0);
      if (c == 121) checkOutput("b2b_gap_high", bus0.tx_out, 1'b1);
      if (c == 122) checkOutput("b2b_second_start", bus0.tx_out, 1'b0);
      if (c == 134) checkOutput("b2b_second_data", bus0.tx_out, 1'b1);
    end
    checkOutputWord("b2b_done_count", done_cnt, 32'd2);
    checkOutputWord("b2b_first_done", first_done, 32'd121);
    checkOutputWord("b2b_second_done", second_done, 32'd242);

    // Fast narrow instance: word 0x6, one cycle per chip
    @(negedge clk);
    bus1.data_valid = 1'b1;
    bus1.data_in    = 4'h6;
    @(posedge clk);
    pat = 18'b000000_111111_000_111;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) bus1.data_valid = 1'b0;
      if (c <= 18) begin
        checkOutput("fast_tx", bus1.tx_out, pat[17]);
        pat = pat << 1;
      end else begin
        checkOutput("fast_done", bus1.tx_done, 1'b1);
      end
    end

    // Valid pulse and data changes during DATA are ignored
    applyStimulus(8'h3C);
    runFrame0("hold", 10'b1_00111100_0, 1'b1);

    // Reset at cycle 50 of a frame
    applyStimulus(8'h00);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) bus0.data_valid = 1'b0;
    end
    checkOutput("pre_rst_tx", bus0.tx_out, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx", bus0.tx_out, 1'b1);
    checkOutput("mid_rst_ready", bus0.data_ready, 1'b1);
    checkOutput("mid_rst_busy", bus0.tx_busy, 1'b0);
    checkOutput("mid_rst_done", bus0.tx_done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_hold_done", bus0.tx_done, 1'b0);
    end
    rst_n           = 1'b1;
    bus0.data_valid = 1'b1;
    bus0.data_in    = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    bus0.data_valid = 1'b0;
    checkOutput("post_rst_start", bus0.tx_out, 1'b0);
    checkOutput("post_rst_busy", bus0.tx_busy, 1'b1);
    repeat (12) @(negedge clk);
    checkOutput("post_rst_bit0", bus0.tx_out, 1'b1);
    repeat (108) @(negedge clk);
    checkOutput("post_rst_done", bus0.tx_done, 1'b1);

    // Loopback through a majority vote with one chip per triplet inverted
    for (int n = 0; n < 256; n++) begin
      word = 8'($urandom_range(0, 255));
      applyStimulus(word);
      chips = '0;
      for (int c = 1; c <= frame_cycles(8, 4) + 1; c++) begin
        @(negedge clk);
        if (c == 1) bus0.data_valid = 1'b0;
        if (c <= 120 && ((c - 1) % 4) == 1) chips = {bus0.tx_out, chips[29:1]};
        if (c == 121) checkOutput("lb_done", bus0.tx_done, 1'b1);
      end
      decoded = '0;
      for (int b = 0; b < 10; b++) begin
        t    = chips >> (b * CHIPS_PER_BIT);
        flip = int'($urandom_range(0, 2));
        v    = t[2:0] ^ (3'b001 << flip);
        decoded = {(v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]), decoded[9:1]};
      end
      checkOutputWord("lb_word", 32'(decoded), 32'({1'b1, word, 1'b0}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
